poly_link_host: RTL
===================

# poly_link_host

Host-side protocol engine for the polynomial-search serial link: frames candidate tap polynomials as START/payload/END, sends them out, and checks the single-byte reply. It also parses unsolicited FOUND frames and FAIL notices from the search array, and keeps count of occupied search modules. It sits between a local job source and the existing byte-level Transmitter/Receiver pair, so one FPGA or a self-test harness can drive a remote search array.

## Interface
- NUM_OF_TAPS, 5, payload bytes per polynomial
- NUM_OF_MODULES, 20, search modules at the far end; sets credit limit
- TIMEOUT_CYCLES, 2_000_000, reply wait limit in clk cycles (≥ 2)
- clk  in  1  single clock, all logic on rising edge
- res  in  1  reset; synchronous, active-low
- cmd_valid  in  1  polynomial offered
- cmd_ready  out  1  polynomial accepted when cmd_valid & cmd_ready
- cmd_poly  in  NUM_OF_TAPS*8  polynomial; byte k (1-based) = bits [k*8-1 -: 8]
- tx_byte  out  8  byte to Transmitter din
- tx_drl  out  1  byte pending, to Transmitter drl
- tx_load  in  1  one-cycle pulse: Transmitter latched tx_byte
- rx_byte  in  8  Receiver dout
- rx_take  in  1  one-cycle pulse: rx_byte valid
- ack, err, fail, timeout, reject, proto_err  out  1 each  one-cycle event pulses
- found_valid  out  1  one-cycle pulse; found_poly valid
- found_poly  out  NUM_OF_TAPS*8  last received FOUND polynomial, same byte order as cmd_poly
- busy_count  out  8  search modules currently holding a polynomial

## Operation
- Codes: START F0, END FF, ACCK F1, ERR EE, FAIL F2. Payload is sent and received byte 1 first, i.e. LSB byte first.
- TX FSM states: IDLE, SEND, WAIT_RESP.
  - IDLE: cmd_ready = 1 iff busy_count < NUM_OF_MODULES.
  - On handshake, if any payload byte == FF: pulse reject and stay in IDLE. The far end would take that byte as END.
  - Otherwise latch cmd_poly, go to SEND with index 0.
- SEND: index 0 sends F0, indexes 1..NUM_OF_TAPS send the payload, index NUM_OF_TAPS+1 sends FF.
  - Each tx_load advances the index.
  - tx_load on the END byte drops tx_drl and moves to WAIT_RESP with the timeout counter cleared.
- WAIT_RESP:
  - F1: pulse ack, busy_count +1, go to IDLE.
  - EE: pulse err, go to IDLE.
  - Counter reaching TIMEOUT_CYCLES-1: pulse timeout, go to IDLE.
  - F0 and F2 are handled by the RX parser below, and the FSM keeps waiting.
- RX parser runs concurrently. States: R_IDLE, R_PAYLOAD, R_END.
  - R_IDLE: F0 goes to R_PAYLOAD with count 1. F2 pulses fail and decrements busy_count. F1/EE go to the TX FSM. F1/EE outside WAIT_RESP, or any other byte, pulse proto_err.
  - R_PAYLOAD: every byte is stored as data, with no code checking. After NUM_OF_TAPS bytes go to R_END.
  - R_END: FF copies the shadow buffer to found_poly, pulses found_valid, decrements busy_count, goes to R_IDLE. Any other byte pulses proto_err, discards the frame, goes to R_IDLE.
- busy_count saturates at 0 on decrement. A same-cycle increment and decrement leaves it unchanged.

## Timing
- Reset values: cmd_ready 0 during reset, tx_drl 0, tx_byte 00, all pulses 0, found_poly 0, busy_count 0. Both FSMs go to idle states and counters clear.
- Reset mid-frame aborts immediately: tx_drl = 0 the next cycle, and the partial rx frame is discarded.
- First tx_byte (F0) and tx_drl = 1 appear the cycle after the cmd handshake.
- tx_byte holds stable while tx_drl = 1. After tx_load the next byte is presented the following cycle.
- A frame costs NUM_OF_TAPS+2 tx_load pulses.
- All event pulses occur 1 cycle after the causing rx_take or tx_load, or after the terminal timeout count.
- found_valid and found_poly update in the same cycle. found_poly then holds until the next valid frame.
- A new command is not accepted before the cycle after leaving WAIT_RESP.

## Structure
- Shared package `poly_link_pkg` holds:
  - code constants START/END/ACCK/ERR/FAIL;
  - TX state encoding;
  - RX state encoding.
- Sub-module `poly_frame_parser` contains the RX parser: shadow buffer, found_poly, found_valid, fail, proto_err, and an F1/EE indication to the parent.
- The parent holds the TX FSM, the timeout counter, and busy_count.

## Test plan
- cmd_poly 0x0102030405 accepted → tx bytes F0,05,04,03,02,01,FF; reply F1 → ack pulse, busy_count 1.
- Reply EE → err pulse, busy_count unchanged; any payload byte FF → reject, no tx_drl.
- No reply for TIMEOUT_CYCLES (set 100) → timeout on cycle 100 after the END tx_load; FSM back in IDLE.
- Rx F0,AA,BB,CC,DD,EE,FF while in WAIT_RESP → found_poly 0xEEDDCCBBAA, found_valid, busy_count −1. Payload EE is not read as ERR. FSM still waiting.
- Fill NUM_OF_MODULES=2 via two ACKs → cmd_ready 0; rx F2 → fail, cmd_ready 1.
- Frame F0 + 5 bytes + 00 → proto_err, no found_valid; reset asserted mid-SEND → tx_drl 0 the next cycle, busy_count 0.

Source files
------------

// File: rtl/poly_link_pkg.sv
// Shared definitions for the polynomial-search link host.
// Holds the link byte codes and the state encodings of the transmit
// FSM and the receive frame parser.
package poly_link_pkg;

  // Link control codes
  localparam logic [7:0] CODE_START = 8'hF0;
  localparam logic [7:0] CODE_END   = 8'hFF;
  localparam logic [7:0] CODE_ACCK  = 8'hF1;
  localparam logic [7:0] CODE_ERR   = 8'hEE;
  localparam logic [7:0] CODE_FAIL  = 8'hF2;

  // Transmit side: wait for a job, stream the frame, wait for the reply
  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_SEND      = 2'd1,
    TX_WAIT_RESP = 2'd2
  } txState_e;

  // Receive side: look for a code, collect a FOUND payload, expect END
  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_PAYLOAD = 2'd1,
    R_END     = 2'd2
  } rxState_e;

endpackage

// File: rtl/poly_link_host_if.sv
// Bundle of the job handshake and the byte-level Transmitter/Receiver
// signals of the link host.
//   cmd_valid/cmd_ready/cmd_poly : job offer from the local source
//   tx_byte/tx_drl/tx_load       : byte stream towards the Transmitter
//   rx_byte/rx_take              : bytes arriving from the Receiver
// slave  : the host engine side
// master : the job source / transceiver side (testbench or wrapper)
interface poly_link_host_if #(
  parameter int NUM_OF_TAPS = 5
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [NUM_OF_TAPS*8-1:0] cmd_poly;
  logic [7:0]               tx_byte;
  logic                     tx_drl;
  logic                     tx_load;
  logic [7:0]               rx_byte;
  logic                     rx_take;

  modport slave (
    input  cmd_valid, cmd_poly, tx_load, rx_byte, rx_take,
    output cmd_ready, tx_byte, tx_drl
  );

  modport master (
    output cmd_valid, cmd_poly, tx_load, rx_byte, rx_take,
    input  cmd_ready, tx_byte, tx_drl
  );
endinterface

// File: rtl/poly_frame_parser.sv
// Receive-side parser of the link host.
// Recognises FOUND frames (START, payload, END), FAIL notices and the
// single-byte ACCK/ERR replies, which are handed to the parent only while
// it is waiting for a reply.
//   clk, res          : clock, synchronous active-low reset
//   rxTake_i/rxByte_i : received byte strobe and data
//   inWait_i          : parent transmit FSM is waiting for a reply
//   respAck_o/respErr_o : same-cycle ACCK/ERR indication to the parent
//   freeSlot_o        : same-cycle request to decrement the busy count
//   fail_o, protoErr_o, foundValid_o : registered one-cycle pulses
//   foundPoly_o       : last complete FOUND polynomial
module poly_frame_parser
  import poly_link_pkg::*;
#(
  parameter int NUM_OF_TAPS = 5
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     rxTake_i,
  input  logic [7:0]               rxByte_i,
  input  logic                     inWait_i,
  output logic                     respAck_o,
  output logic                     respErr_o,
  output logic                     freeSlot_o,
  output logic                     fail_o,
  output logic                     protoErr_o,
  output logic                     foundValid_o,
  output logic [NUM_OF_TAPS*8-1:0] foundPoly_o
);

  localparam int W     = NUM_OF_TAPS * 8;
  localparam int CNT_W = $clog2(NUM_OF_TAPS + 1);

  rxState_e         rxState_q, rxState_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     shadow_q, shadow_d;
  logic [W-1:0]     foundPoly_q, foundPoly_d;
  logic             fail_q, fail_d;
  logic             protoErr_q, protoErr_d;
  logic             foundValid_q, foundValid_d;

  // State and output registers; reset also throws away any partly
  // received frame held in the shadow buffer.
  always_ff @(posedge clk) begin
    if (!res) begin
      rxState_q    <= R_IDLE;
      count_q      <= '0;
      shadow_q     <= '0;
      foundPoly_q  <= '0;
      fail_q       <= 1'b0;
      protoErr_q   <= 1'b0;
      foundValid_q <= 1'b0;
    end else begin
      rxState_q    <= rxState_d;
      count_q      <= count_d;
      shadow_q     <= shadow_d;
      foundPoly_q  <= foundPoly_d;
      fail_q       <= fail_d;
      protoErr_q   <= protoErr_d;
      foundValid_q <= foundValid_d;
    end
  end

  // Next-state logic. Payload bytes are stored blindly so that data bytes
  // equal to a code value are never misread as that code; only the byte
  // after the payload must be END for the frame to count.
  always_comb begin
    rxState_d    = rxState_q;
    count_d      = count_q;
    shadow_d     = shadow_q;
    foundPoly_d  = foundPoly_q;
    fail_d       = 1'b0;
    protoErr_d   = 1'b0;
    foundValid_d = 1'b0;
    respAck_o    = 1'b0;
    respErr_o    = 1'b0;
    freeSlot_o   = 1'b0;
    if (rxTake_i) begin
      unique case (rxState_q)
        R_IDLE: begin
          if (rxByte_i == CODE_START) begin
            rxState_d = R_PAYLOAD;
            count_d   = CNT_W'(1);
          end else if (rxByte_i == CODE_FAIL) begin
            fail_d     = 1'b1;
            freeSlot_o = 1'b1;
          end else if (inWait_i && rxByte_i == CODE_ACCK) begin
            respAck_o = 1'b1;
          end else if (inWait_i && rxByte_i == CODE_ERR) begin
            respErr_o = 1'b1;
          end else begin
            protoErr_d = 1'b1;
          end
        end
        R_PAYLOAD: begin
          for (int k = 1; k <= NUM_OF_TAPS; k++) begin
            if (int'(count_q) == k) shadow_d[k*8-1 -: 8] = rxByte_i;
          end
          if (int'(count_q) == NUM_OF_TAPS) rxState_d = R_END;
          else count_d = count_q + CNT_W'(1);
        end
        R_END: begin
          if (rxByte_i == CODE_END) begin
            foundPoly_d  = shadow_q;
            foundValid_d = 1'b1;
            freeSlot_o   = 1'b1;
          end else begin
            protoErr_d = 1'b1;
          end
          rxState_d = R_IDLE;
        end
        default: rxState_d = R_IDLE;
      endcase
    end
  end

  assign fail_o       = fail_q;
  assign protoErr_o   = protoErr_q;
  assign foundValid_o = foundValid_q;
  assign foundPoly_o  = foundPoly_q;

endmodule

// File: rtl/poly_link_host.sv
// Host-side protocol engine of the polynomial-search link.
// Frames each accepted polynomial as START, payload (byte 1 first), END,
// hands the bytes to the Transmitter, then waits for the one-byte reply.
// Also tracks how many far-end search modules hold a polynomial.
//   clk, res  : clock, synchronous active-low reset
//   link      : job handshake plus Transmitter/Receiver byte signals
//   ack, err, timeout, reject : transmit-side one-cycle event pulses
//   fail, proto_err, found_valid : receive-side one-cycle event pulses
//   found_poly : last polynomial reported in a FOUND frame
//   busy_count : search modules currently holding a polynomial
module poly_link_host
  import poly_link_pkg::*;
#(
  parameter int NUM_OF_TAPS    = 5,
  parameter int NUM_OF_MODULES = 20,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                     clk,
  input  logic                     res,
  poly_link_host_if.slave          link,
  output logic                     ack,
  output logic                     err,
  output logic                     fail,
  output logic                     timeout,
  output logic                     reject,
  output logic                     proto_err,
  output logic                     found_valid,
  output logic [NUM_OF_TAPS*8-1:0] found_poly,
  output logic [7:0]               busy_count
);

  localparam int W     = NUM_OF_TAPS * 8;
  localparam int IDX_W = $clog2(NUM_OF_TAPS + 2);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OF_TAPS + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  txState_e         txState_q, txState_d;
  logic [IDX_W-1:0] byteIdx_q, byteIdx_d;
  logic [W-1:0]     poly_q, poly_d;
  logic [TO_W-1:0]  timeoutCnt_q, timeoutCnt_d;
  logic [7:0]       busyCount_q, busyCount_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             timeout_q, timeout_d;
  logic             reject_q, reject_d;

  logic       cmdReady;
  logic       hasEndByte;
  logic [7:0] txByte;
  logic       busyInc;
  logic       inWait;
  logic       respAck, respErr, freeSlot;

  assign inWait = (txState_q == TX_WAIT_RESP);

  poly_frame_parser #(
    .NUM_OF_TAPS(NUM_OF_TAPS)
  ) u_parser (
    .clk          (clk),
    .res          (res),
    .rxTake_i     (link.rx_take),
    .rxByte_i     (link.rx_byte),
    .inWait_i     (inWait),
    .respAck_o    (respAck),
    .respErr_o    (respErr),
    .freeSlot_o   (freeSlot),
    .fail_o       (fail),
    .protoErr_o   (proto_err),
    .foundValid_o (found_valid),
    .foundPoly_o  (found_poly)
  );

  // State register for the transmit FSM, timeout counter and busy count;
  // a reset mid-frame simply drops back to idle so tx_drl falls at once.
  always_ff @(posedge clk) begin
    if (!res) begin
      txState_q    <= TX_IDLE;
      byteIdx_q    <= '0;
      poly_q       <= '0;
      timeoutCnt_q <= '0;
      busyCount_q  <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      txState_q    <= txState_d;
      byteIdx_q    <= byteIdx_d;
      poly_q       <= poly_d;
      timeoutCnt_q <= timeoutCnt_d;
      busyCount_q  <= busyCount_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
      reject_q     <= reject_d;
    end
  end

  // A payload byte equal to END would make the far end close the frame
  // early, so such polynomials are refused at the handshake.
  always_comb begin
    hasEndByte = 1'b0;
    for (int k = 0; k < NUM_OF_TAPS; k++) begin
      if (link.cmd_poly[k*8 +: 8] == CODE_END) hasEndByte = 1'b1;
    end
  end

  // Transmit FSM next-state logic. The reply wait gives ACCK/ERR priority
  // over a timeout landing in the same cycle.
  always_comb begin
    txState_d    = txState_q;
    byteIdx_d    = byteIdx_q;
    poly_d       = poly_q;
    timeoutCnt_d = timeoutCnt_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    timeout_d    = 1'b0;
    reject_d     = 1'b0;
    busyInc      = 1'b0;
    cmdReady     = 1'b0;
    unique case (txState_q)
      TX_IDLE: begin
        cmdReady = res && (busyCount_q < 8'(NUM_OF_MODULES));
        if (link.cmd_valid && cmdReady) begin
          if (hasEndByte) begin
            reject_d = 1'b1;
          end else begin
            poly_d    = link.cmd_poly;
            byteIdx_d = '0;
            txState_d = TX_SEND;
          end
        end
      end
      TX_SEND: begin
        if (link.tx_load) begin
          if (byteIdx_q == IDX_LAST) begin
            txState_d    = TX_WAIT_RESP;
            timeoutCnt_d = '0;
          end else begin
            byteIdx_d = byteIdx_q + IDX_W'(1);
          end
        end
      end
      TX_WAIT_RESP: begin
        if (respAck) begin
          ack_d     = 1'b1;
          busyInc   = 1'b1;
          txState_d = TX_IDLE;
        end else if (respErr) begin
          err_d     = 1'b1;
          txState_d = TX_IDLE;
        end else if (timeoutCnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          txState_d = TX_IDLE;
        end else begin
          timeoutCnt_d = timeoutCnt_q + TO_W'(1);
        end
      end
      default: txState_d = TX_IDLE;
    endcase
  end

  // Byte presented to the Transmitter: START, payload byte 1 first, END.
  // Driven purely from registers so it stays put until the next tx_load.
  always_comb begin
    txByte = 8'h00;
    if (txState_q == TX_SEND) begin
      if (byteIdx_q == '0) begin
        txByte = CODE_START;
      end else if (byteIdx_q == IDX_LAST) begin
        txByte = CODE_END;
      end else begin
        for (int k = 1; k <= NUM_OF_TAPS; k++) begin
          if (int'(byteIdx_q) == k) txByte = poly_q[k*8-1 -: 8];
        end
      end
    end
  end

  // Busy count: an ACCK and a release in the same cycle cancel out, and a
  // release with nothing outstanding leaves the count at zero.
  always_comb begin
    busyCount_d = busyCount_q;
    if (busyInc && !freeSlot) begin
      busyCount_d = busyCount_q + 8'd1;
    end else if (!busyInc && freeSlot && busyCount_q != 8'd0) begin
      busyCount_d = busyCount_q - 8'd1;
    end
  end

  assign link.cmd_ready = cmdReady;
  assign link.tx_byte   = txByte;
  assign link.tx_drl    = (txState_q == TX_SEND);
  assign ack            = ack_q;
  assign err            = err_q;
  assign timeout        = timeout_q;
  assign reject         = reject_q;
  assign busy_count     = busyCount_q;

endmodule
